// File: rtl/multiword_add_seq_pkg.sv
// multiword_add_seq_pkg: shared FSM states, slice width and op encoding for multiword_add_seq
package multiword_add_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 16;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/multiword_add_seq_add_pg.sv
// add_pg_16: 16-bit adder slice with carry in/out and group propagate/generate (val1, val2, carry_in -> val_out, carry_out, prop_out, gen_out)
module add_pg_16 (
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic        carry_in,
  output logic [15:0] val_out,
  output logic        carry_out,
  output logic        prop_out,
  output logic        gen_out
);
  assign {carry_out, val_out} = {1'b0, val1} + {1'b0, val2} + 17'(carry_in);
  assign prop_out = &(val1 ^ val2);
  // when every bit propagates the carry out is carry_in itself, otherwise it is the group generate
  assign gen_out = carry_out & ~(prop_out & carry_in);
endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: WORDS x 16-bit add/sub over WORDS cycles on one shared slice (clk, rst_n, in_valid/in_ready/op_sub/a/b in, out_valid/out_ready/result/carry_out/overflow/zero out)
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op_sub,
  input  logic [SLICE_W*WORDS-1:0]   a,
  input  logic [SLICE_W*WORDS-1:0]   b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SLICE_W*WORDS-1:0]   result,
  output logic                       carry_out,
  output logic                       overflow,
  output logic                       zero
);
  localparam int W = SLICE_W * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t state, state_nxt;
  logic [IW-1:0] idx;
  logic cy, last, s_co, unused_prop, unused_gen;
  logic [W-1:0] opa, opb, res_nxt;
  logic [SLICE_W-1:0] s_a, s_b, s_sum;
  assign last = idx == IW'(WORDS - 1);
  assign s_a = opa[idx*SLICE_W +: SLICE_W];
  assign s_b = opb[idx*SLICE_W +: SLICE_W];
  add_pg_16 u_slice (
    .val1      (s_a),
    .val2      (s_b),
    .carry_in  (cy),
    .val_out   (s_sum),
    .carry_out (s_co),
    .prop_out  (unused_prop),
    .gen_out   (unused_gen)
  );
  // full result as it will look after this slice is written, so zero covers all words
  always_comb begin
    res_nxt = result;
    res_nxt[idx*SLICE_W +: SLICE_W] = s_sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                                (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      cy <= 1'b0;
      opa <= '0;
      opb <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      // subtraction is a + ~b + 1: invert b and seed the carry
      opa <= a;
      opb <= op_sub == OP_ADD ? b : ~b;
      cy <= op_sub == OP_SUB;
      idx <= '0;
    end else if (state == RUN) begin
      result <= res_nxt;
      cy <= s_co;
      idx <= idx + 1'b1;
      if (last) begin
        carry_out <= s_co;
        overflow <= (opa[W-1] == opb[W-1]) & (s_sum[SLICE_W-1] != opa[W-1]);
        zero <= res_nxt == '0;
      end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// tb_multiword_add_seq: directed self-checking bench for multiword_add_seq with WORDS=4
module tb_multiword_add_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b0;
  logic [63:0] a = '0, b = '0, result;
  logic in_ready, out_valid, carry_out, overflow, zero;
  int passed = 0, total = 0;

  multiword_add_seq #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic sub, input logic [63:0] xa, input logic [63:0] xb,
                        output int lat, output logic [63:0] r, output logic c, output logic ov, output logic z);
    in_valid = 1'b1; op_sub = sub; a = xa; b = xb; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    r = result; c = carry_out; ov = overflow; z = zero;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if ({result, carry_out, overflow, zero} !== 67'd0) $display("FAIL reset_outputs got %h %b%b%b want 0", result, carry_out, overflow, zero); else passed++;
  endtask

  task automatic test_add_basic();
    int lat; logic [63:0] r; logic c, ov, z;
    run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'd1, lat, r, c, ov, z);
    total++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else passed++;
    total++; if (r !== 64'h0000_0000_0001_0000) $display("FAIL add_result got %h want 0000000000010000", r); else passed++;
    total++; if ({c, ov, z} !== 3'b000) $display("FAIL add_flags got c%b v%b z%b want 000", c, ov, z); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL add_ready_after got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_add_wrap();
    int lat; logic [63:0] r; logic c, ov, z;
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, lat, r, c, ov, z);
    total++; if (r !== 64'd0) $display("FAIL wrap_result got %h want 0", r); else passed++;
    total++; if ({c, ov, z} !== 3'b101) $display("FAIL wrap_flags got c%b v%b z%b want c1 v0 z1", c, ov, z); else passed++;
  endtask

  task automatic test_sub();
    int lat; logic [63:0] r; logic c, ov, z;
    run_op(1'b1, 64'd5, 64'd7, lat, r, c, ov, z);
    total++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_neg_result got %h want fffffffffffffffe", r); else passed++;
    total++; if ({c, ov, z} !== 3'b000) $display("FAIL sub_neg_flags got c%b v%b z%b want 000", c, ov, z); else passed++;
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, lat, r, c, ov, z);
    total++; if (r !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_ovf_result got %h want 7fffffffffffffff", r); else passed++;
    total++; if ({c, ov, z} !== 3'b110) $display("FAIL sub_ovf_flags got c%b v%b z%b want c1 v1 z0", c, ov, z); else passed++;
    total++; if (lat !== 4) $display("FAIL sub_latency got %0d want 4", lat); else passed++;
  endtask

  task automatic test_add_ovf();
    int lat; logic [63:0] r; logic c, ov, z;
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, lat, r, c, ov, z);
    total++; if (r !== 64'h8000_0000_0000_0000) $display("FAIL add_ovf_result got %h want 8000000000000000", r); else passed++;
    total++; if ({c, ov, z} !== 3'b010) $display("FAIL add_ovf_flags got c%b v%b z%b want c0 v1 z0", c, ov, z); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1; op_sub = 1'b0; a = 64'd1; b = 64'd2; out_ready = 1'b0;
    tick();
    a = 64'd10; b = 64'd20;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if ({out_valid, in_ready, result, carry_out, overflow, zero} !== {2'b10, 64'd3, 3'b000})
        $display("FAIL bp_hold%0d got v%b r%b %h c%b o%b z%b want v1 r0 3 000", i, out_valid, in_ready, result, carry_out, overflow, zero);
      else passed++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL bp_release got r%b v%b want r1 v0", in_ready, out_valid); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_accept got in_ready %b want 0", in_ready); else passed++;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++; if (lat !== 4 || result !== 64'd30) $display("FAIL bp_second got lat %0d result %h want 4 1e", lat, result); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [63:0] r; logic c, ov, z;
    in_valid = 1'b1; op_sub = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL rst_mid_hs got v%b r%b want v0 r1", out_valid, in_ready); else passed++;
    total++; if ({result, carry_out, overflow, zero} !== 67'd0) $display("FAIL rst_mid_outputs got %h %b%b%b want 0", result, carry_out, overflow, zero); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_after got out_valid %b want 0", out_valid); else passed++;
    run_op(1'b0, 64'd3, 64'd4, lat, r, c, ov, z);
    total++; if (lat !== 4 || r !== 64'd7) $display("FAIL rst_mid_next got lat %0d result %h want 4 7", lat, r); else passed++;
    total++; if ({c, ov, z} !== 3'b000) $display("FAIL rst_mid_flags got c%b v%b z%b want 000", c, ov, z); else passed++;
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    tick();
    test_add_basic();
    test_add_wrap();
    test_sub();
    test_add_ovf();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
